regfile_param_clr: RTL and testbench

Parametrised multi-read-port register file for the CPU datapath, generalising the fixed 32x32-bit, two-read-port file. Width, depth and read-port count are parameters. Register 0 is optionally hard-wired to zero. Write-to-read bypass is optional. Storage is cleared by a one-entry-per-cycle sweep sequencer, started by reset or on request, rather than a single-cycle array reset, so the array maps onto distributed RAM.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clear_seq.sv | 60 ++++++
 rtl/regfile_param_clr.sv | 75 +++++++
 tb/tb_regfile_param_clr.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and defaults.
// Sweep state encoding plus default datapath widths.
package regfile_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } sweep_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear-sweep sequencer for the register file.
// Walks every entry once per sweep, one entry per cycle.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Clear_Req,
  output logic              Busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  sweep_state_t      state;
  sweep_state_t      state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;

  // State and pointer register; reset (re)starts a sweep at entry 0.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next state: requests only start a sweep from idle.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      ST_IDLE: begin
        if (Clear_Req) begin
          state_nxt = ST_CLEAR;
          ptr_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        ptr_nxt = ptr + ADDR_W'(1);
        if (&ptr) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  assign Busy     = (state == ST_CLEAR);
  assign clr_en   = Busy && Reset_n;
  assign clr_addr = ptr;

endmodule

// File: rtl/regfile_param_clr.sv
// Parametrised multi-read-port register file.
// Storage has no array reset; a sweep sequencer zeroes it.
module regfile_param_clr
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Write_Reg,
  input  logic [ADDR_W-1:0]        W_Addr,
  input  logic [DATA_W-1:0]        W_Data,
  input  logic [NUM_RD*ADDR_W-1:0] R_Addr,
  output logic [NUM_RD*DATA_W-1:0] R_Data,
  input  logic                     Clear_Req,
  output logic                     Busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              w_zero;
  logic              we_ok;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_seq (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Clear_Req (Clear_Req),
    .Busy      (Busy),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr)
  );

  assign w_zero = (ZERO_REG != 0) && (W_Addr == '0);
  assign we_ok  = Write_Reg && !Busy && Reset_n && !w_zero;

  // Single write port: the sweep owns it while active.
  always_ff @(posedge Clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (we_ok) begin
      mem[W_Addr] <= W_Data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = R_Addr[k*ADDR_W +: ADDR_W];

    // Read mux: sweep, zero register, bypass, then storage.
    always_comb begin
      rd = mem[ra];
      if (Busy) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
      end else if ((BYPASS != 0) && Write_Reg && (W_Addr == ra)) begin
        rd = W_Data;
      end
    end

    assign R_Data[k*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_param_clr.sv
// Self-checking bench for regfile_param_clr.
// Random and directed stimulus against an array model.
module tb_regfile_param_clr;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int DEPTH = 32;

  logic           Clk;
  logic           Reset_n;
  logic           Write_Reg;
  logic [AW-1:0]  W_Addr;
  logic [DW-1:0]  W_Data;
  logic [NR*AW-1:0] R_Addr;
  logic [NR*DW-1:0] R_Data;
  logic           Clear_Req;
  logic           Busy;
  logic [AW-1:0]  nb_addr;
  logic [DW-1:0]  nb_data;
  logic           nb_busy;

  int n_vec;
  int n_bad;

  logic [DW-1:0] mdl [DEPTH];
  int busy_left;

  regfile_param_clr #(
    .DATA_W (DW), .ADDR_W (AW), .NUM_RD (NR),
    .ZERO_REG (1), .BYPASS (1)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Write_Reg (Write_Reg),
    .W_Addr    (W_Addr),
    .W_Data    (W_Data),
    .R_Addr    (R_Addr),
    .R_Data    (R_Data),
    .Clear_Req (Clear_Req),
    .Busy      (Busy)
  );

  regfile_param_clr #(
    .DATA_W (DW), .ADDR_W (AW), .NUM_RD (1),
    .ZERO_REG (1), .BYPASS (0)
  ) dut_nb (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Write_Reg (Write_Reg),
    .W_Addr    (W_Addr),
    .W_Data    (W_Data),
    .R_Addr    (nb_addr),
    .R_Data    (nb_data),
    .Clear_Req (Clear_Req),
    .Busy      (nb_busy)
  );

  assign nb_addr = R_Addr[AW-1:0];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a,
                                           input bit byp);
    if (busy_left > 0) return '0;
    if (a == '0) return '0;
    if (byp && Write_Reg && W_Addr == a) return W_Data;
    return mdl[a];
  endfunction

  function automatic logic [DW-1:0] port(input int p);
    return R_Data[p*DW +: DW];
  endfunction

  function automatic logic [AW-1:0] paddr(input int p);
    return R_Addr[p*AW +: AW];
  endfunction

  // One clock edge: update the model from the inputs present at the edge.
  task automatic tick();
    @(posedge Clk);
    if (!Reset_n) begin
      busy_left = DEPTH;
      foreach (mdl[i]) mdl[i] = '0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (Write_Reg && W_Addr != '0) mdl[W_Addr] = W_Data;
      if (Clear_Req) begin
        foreach (mdl[i]) mdl[i] = '0;
        busy_left = DEPTH;
      end
    end
    #1;
  endtask

  task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    R_Addr = {a3, a2, a1, a0};
  endtask

  task automatic test_reset();
    int cnt;
    Reset_n = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;
    set_raddr(5, 31, 5, 31);
    cnt = 0;
    while (Busy === 1'b1 && cnt < 100) begin
      #1;
      for (int p = 0; p < NR; p++) begin
        n_vec++;
        if (port(p) !== '0) begin
          n_bad++;
          $display("FAIL reset_rd p%0d got %h exp 0", p, port(p));
        end
      end
      tick();
      cnt++;
    end
    n_vec++;
    if (cnt != DEPTH) begin
      n_bad++;
      $display("FAIL reset_busy_len got %0d exp %0d", cnt, DEPTH);
    end
    #1;
    for (int p = 0; p < 2; p++) begin
      n_vec++;
      if (port(p) !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_idle_rd p%0d got %h exp 0", p, port(p));
      end
    end
  endtask

  task automatic test_write_readback();
    Write_Reg = 1'b1;
    W_Addr = 7;
    W_Data = 32'hDEADBEEF;
    set_raddr(7, 7, 7, 7);
    #1;
    n_vec++;
    if (port(0) !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL wr_bypass got %h exp deadbeef", port(0));
    end
    n_vec++;
    if (nb_data !== 32'h0) begin
      n_bad++;
      $display("FAIL wr_nobypass got %h exp 0", nb_data);
    end
    tick();
    Write_Reg = 1'b0;
    #1;
    for (int p = 0; p < NR; p++) begin
      n_vec++;
      if (port(p) !== 32'hDEADBEEF) begin
        n_bad++;
        $display("FAIL wr_store p%0d got %h exp deadbeef", p, port(p));
      end
    end
    n_vec++;
    if (nb_data !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL wr_store_nb got %h exp deadbeef", nb_data);
    end
  endtask

  task automatic test_zero_reg();
    Write_Reg = 1'b1;
    W_Addr = 0;
    W_Data = 32'h12345678;
    set_raddr(0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int p = 0; p < NR; p++) begin
        n_vec++;
        if (port(p) !== 32'h0) begin
          n_bad++;
          $display("FAIL zero_reg c%0d p%0d got %h exp 0", c, p, port(p));
        end
      end
      n_vec++;
      if (nb_data !== 32'h0) begin
        n_bad++;
        $display("FAIL zero_reg_nb c%0d got %h exp 0", c, nb_data);
      end
      tick();
      if (c == 1) Write_Reg = 1'b0;
    end
  endtask

  task automatic test_clear_during_use();
    int cnt;
    for (int i = 1; i < DEPTH; i++) begin
      Write_Reg = 1'b1;
      W_Addr = AW'(i);
      W_Data = i;
      tick();
    end
    Write_Reg = 1'b0;
    set_raddr(9, 31, 1, 17);
    #1;
    n_vec++;
    if (port(0) !== 32'd9 || port(1) !== 32'd31) begin
      n_bad++;
      $display("FAIL fill got %h %h exp 9 31", port(0), port(1));
    end
    Clear_Req = 1'b1;
    Write_Reg = 1'b1;
    W_Addr = 9;
    W_Data = 32'hCAFE0009;
    tick();
    Clear_Req = 1'b0;
    cnt = 0;
    while (Busy === 1'b1 && cnt < 100) begin
      Write_Reg = 1'b1;
      W_Addr = AW'($urandom_range(1, 31));
      W_Data = $urandom;
      set_raddr(W_Addr, 9, AW'($urandom), 31);
      #1;
      for (int p = 0; p < NR; p++) begin
        n_vec++;
        if (port(p) !== '0) begin
          n_bad++;
          $display("FAIL clr_busy_rd c%0d p%0d got %h exp 0", cnt, p, port(p));
        end
      end
      tick();
      cnt++;
    end
    n_vec++;
    if (cnt != DEPTH) begin
      n_bad++;
      $display("FAIL clr_busy_len got %0d exp %0d", cnt, DEPTH);
    end
    Write_Reg = 1'b0;
    set_raddr(9, 1, 31, 17);
    #1;
    for (int p = 0; p < NR; p++) begin
      n_vec++;
      if (port(p) !== exp_rd(paddr(p), 1)) begin
        n_bad++;
        $display("FAIL clr_after p%0d got %h exp %h", p, port(p),
                 exp_rd(paddr(p), 1));
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    Clear_Req = 1'b1;
    tick();
    Clear_Req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    cnt = 0;
    while (Busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    n_vec++;
    if (cnt != DEPTH) begin
      n_bad++;
      $display("FAIL mid_reset_len got %0d exp %0d", cnt, DEPTH);
    end
  endtask

  task automatic test_multiport();
    Write_Reg = 1'b1;
    W_Addr = 3;
    W_Data = 32'hA;
    tick();
    W_Addr = 30;
    W_Data = 32'hB;
    tick();
    Write_Reg = 1'b0;
    set_raddr(3, 3, 30, 0);
    #1;
    n_vec++;
    if (R_Data !== {32'h0, 32'hB, 32'hA, 32'hA}) begin
      n_bad++;
      $display("FAIL multiport got %h exp 0/b/a/a", R_Data);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      Write_Reg = ($urandom_range(0, 3) != 0);
      W_Addr = AW'($urandom);
      W_Data = $urandom;
      Clear_Req = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < NR; p++) begin
        R_Addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? W_Addr
                                                          : AW'($urandom);
      end
      #1;
      n_vec++;
      if (Busy !== (busy_left > 0)) begin
        n_bad++;
        $display("FAIL rnd_busy c%0d got %b exp %b", c, Busy, busy_left > 0);
      end
      for (int p = 0; p < NR; p++) begin
        n_vec++;
        if (port(p) !== exp_rd(paddr(p), 1)) begin
          n_bad++;
          $display("FAIL rnd_rd c%0d p%0d a%0d got %h exp %h", c, p,
                   paddr(p), port(p), exp_rd(paddr(p), 1));
        end
      end
      n_vec++;
      if (nb_data !== exp_rd(nb_addr, 0)) begin
        n_bad++;
        $display("FAIL rnd_nb c%0d got %h exp %h", c, nb_data,
                 exp_rd(nb_addr, 0));
      end
      tick();
    end
    Write_Reg = 1'b0;
    Clear_Req = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    busy_left = DEPTH;
    foreach (mdl[i]) mdl[i] = '0;
    Reset_n = 1'b0;
    Write_Reg = 1'b0;
    W_Addr = '0;
    W_Data = '0;
    R_Addr = '0;
    Clear_Req = 1'b0;
    test_reset();
    test_write_readback();
    test_zero_reg();
    test_clear_during_use();
    test_reset_mid_sweep();
    test_multiport();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
